// File: rtl/sort_2in1_pkg.sv
// Shared constants for the streaming top-16 tracker.
package sort_2in1_pkg;

  // Number of kept entries. The sum width below assumes exactly 16.
  localparam int N = 16;

  // Default sample width in bits.
  localparam int W_DEFAULT = 12;

  // Extra sum bits: 16 * (2^W - 1) < 2^(W+4), so 4 guard bits never overflow.
  localparam int SUM_EXTRA = 4;

  // Width of the running sum for a given sample width.
  function automatic int sum_width(input int w);
    return w + SUM_EXTRA;
  endfunction

endpackage

// File: rtl/sort_2in1_cell.sv
// One slot of the descending-sorted insertion chain.
// gt tells the cell below whether the sample beats this entry. A cell whose
// own gt is set either takes the sample (the cell above did not beat its
// entry, so this is the insertion point) or takes the entry shifted down
// from above (the insertion point is higher up).
module sort_2in1_cell
  import sort_2in1_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         synrst,
  input  logic         en,
  input  logic [W-1:0] din,
  input  logic         upper_gt,
  input  logic [W-1:0] upper_entry,
  output logic         gt,
  output logic [W-1:0] entry
);

  logic [W-1:0] entry_reg;

  // Strict compare: an equal sample lands below existing equal entries.
  assign gt    = din > entry_reg;
  assign entry = entry_reg;

  // Entry register: clear, insert the sample, shift down, or hold.
  always_ff @(posedge clk) begin
    if (synrst) begin
      entry_reg <= '0;
    end else if (en && gt) begin
      entry_reg <= upper_gt ? upper_entry : din;
    end
  end

endmodule

// File: rtl/sort_2in1.sv
// Streaming top-16 tracker: keeps the 16 largest unsigned samples since
// reset in a descending-sorted register chain and reports the maximum and
// the sum of all kept entries. Both outputs come straight from registers.
module sort_2in1
  import sort_2in1_pkg::*;
#(
  parameter  int W     = W_DEFAULT,
  localparam int SUM_W = sum_width(W)
) (
  input  logic             clk,
  input  logic             synrst,
  input  logic             DataEn,
  input  logic [W-1:0]     DataIn,
  output logic [W-1:0]     DataMax,
  output logic [SUM_W-1:0] DataSumOut
);

  logic         gt_chain  [N];
  logic [W-1:0] entry_arr [N];
  logic [SUM_W-1:0] sum_reg;

  // Cell chain; entry 0 is the largest. The top cell has nothing above it,
  // so it always takes the sample directly when it wins.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_cell
      if (gi == 0) begin : g_top
        sort_2in1_cell #(.W(W)) u_cell (
          .clk         (clk),
          .synrst      (synrst),
          .en          (DataEn),
          .din         (DataIn),
          .upper_gt    (1'b0),
          .upper_entry ({W{1'b0}}),
          .gt          (gt_chain[gi]),
          .entry       (entry_arr[gi])
        );
      end else begin : g_rest
        sort_2in1_cell #(.W(W)) u_cell (
          .clk         (clk),
          .synrst      (synrst),
          .en          (DataEn),
          .din         (DataIn),
          .upper_gt    (gt_chain[gi-1]),
          .upper_entry (entry_arr[gi-1]),
          .gt          (gt_chain[gi]),
          .entry       (entry_arr[gi])
        );
      end
    end
  endgenerate

  // Running sum: a sample is accepted exactly when it beats the last entry,
  // which is then pushed out, so add the newcomer and drop the evicted value.
  always_ff @(posedge clk) begin
    if (synrst) begin
      sum_reg <= '0;
    end else if (DataEn && gt_chain[N-1]) begin
      sum_reg <= sum_reg + SUM_W'(DataIn) - SUM_W'(entry_arr[N-1]);
    end
  end

  assign DataMax    = entry_arr[0];
  assign DataSumOut = sum_reg;

endmodule

// File: tb/tb_sort_2in1.sv
// Self-checking bench for sort_2in1: directed scenarios plus a long random
// stream compared against a sort-based reference model.
module tb_sort_2in1;

  localparam int W = 12;
  localparam int SUM_W = W + 4;

  logic             clk;
  logic             synrst;
  logic             DataEn;
  logic [W-1:0]     DataIn;
  logic [W-1:0]     DataMax;
  logic [SUM_W-1:0] DataSumOut;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference: multiset of the 16 largest samples, kept as a sorted queue.
  int ref_q[$];

  sort_2in1 #(.W(W)) dut (
    .clk        (clk),
    .synrst     (synrst),
    .DataEn     (DataEn),
    .DataIn     (DataIn),
    .DataMax    (DataMax),
    .DataSumOut (DataSumOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic void model_reset();
    ref_q.delete();
    for (int i = 0; i < 16; i++) ref_q.push_back(0);
  endfunction

  function automatic void model_push(input int x);
    ref_q.push_back(x);
    ref_q.rsort();
    void'(ref_q.pop_back());
  endfunction

  function automatic int model_sum();
    int s = 0;
    foreach (ref_q[i]) s += ref_q[i];
    return s;
  endfunction

  // One clock with the given inputs; updates the model and compares outputs.
  task automatic step(input logic rst, input logic en, input int din, input string tag);
    synrst = rst;
    DataEn = en;
    DataIn = W'(din);
    @(posedge clk);
    #1;
    if (rst) model_reset();
    else if (en) model_push(din);
    check({tag, "_max"}, int'(DataMax), ref_q[0]);
    check({tag, "_sum"}, int'(DataSumOut), model_sum());
  endtask

  initial begin
    synrst = 1'b1;
    DataEn = 1'b0;
    DataIn = '0;
    model_reset();

    // Reset then idle zeros.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, "reset");
    check("reset_max_const", int'(DataMax), 0);
    check("reset_sum_const", int'(DataSumOut), 0);
    for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 0, "idle0");
    check("idle_sum_const", int'(DataSumOut), 0);

    // Ascending fill 1..20.
    for (int i = 1; i <= 20; i++) begin
      step(1'b0, 1'b1, i, "asc");
      if (i == 16) check("asc16_sum_const", int'(DataSumOut), 136);
    end
    check("asc_max_const", int'(DataMax), 20);
    check("asc_sum_const", int'(DataSumOut), 200);

    // Gating and rejection.
    step(1'b0, 1'b0, 4000, "gate");
    check("gate_max_const", int'(DataMax), 20);
    check("gate_sum_const", int'(DataSumOut), 200);
    step(1'b0, 1'b1, 3, "reject");
    check("reject_sum_const", int'(DataSumOut), 200);
    step(1'b0, 1'b1, 100, "ins100");
    check("ins100_max_const", int'(DataMax), 100);
    check("ins100_sum_const", int'(DataSumOut), 295);

    // Reset mid-stream, then a single sample.
    step(1'b1, 1'b1, 50, "midrst");
    check("midrst_max_const", int'(DataMax), 0);
    check("midrst_sum_const", int'(DataSumOut), 0);
    step(1'b0, 1'b1, 7, "after_rst");
    check("after_rst_max_const", int'(DataMax), 7);
    check("after_rst_sum_const", int'(DataSumOut), 7);

    // Saturation at full scale.
    step(1'b1, 1'b0, 0, "satrst");
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 4095, "sat");
    check("sat_max_const", int'(DataMax), 4095);
    check("sat_sum_const", int'(DataSumOut), 65520);

    // Random stream; some phases use a narrow range to force many ties.
    step(1'b1, 1'b0, 0, "rndrst");
    for (int i = 0; i < 10000; i++) begin
      int v;
      logic en;
      en = ($urandom_range(0, 3) != 0);
      if ((i / 1000) % 3 == 1) v = $urandom_range(0, 15);
      else v = $urandom_range(0, 4095);
      if (i == 6000) step(1'b1, en, v, "rnd");
      else step(1'b0, en, v, "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
